// File: rtl/axilite_test_pkg.sv
// rtl/axilite_test_pkg.sv - constants shared by the AXI-Lite write-sequence generator and responder
package axilite_test_pkg;

    localparam logic [1:0]  BRESP_OKAY         = 2'b00;
    localparam logic [1:0]  BRESP_SLVERR       = 2'b10;
    localparam logic [63:0] DEFAULT_START_ADDR = 64'h0000_0000_4000_0000;

    // Status word selected by araddr[4:3]
    typedef enum logic [1:0] {
        STAT_WCOUNT = 2'd0,
        STAT_ECOUNT = 2'd1,
        STAT_LADDR  = 2'd2,
        STAT_LDATA  = 2'd3
    } stat_idx_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axilite_chan_hold.sv
// rtl/axilite_chan_hold.sv - single-entry holding register for one AXI-Lite request channel
module axilite_chan_hold #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             stall_i,
    output logic             full_o,
    output logic [WIDTH-1:0] q_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] q_q, q_d;

    // Ready is withheld while rst is high so no beat is captured during reset.
    assign ready_o = !rst && (!full_q || pop_i) && !stall_i;

    always_comb begin
        full_d = full_q;
        q_d    = q_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (valid_i && ready_o) begin
            full_d = 1'b1;
            q_d    = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            q_q    <= '0;
        end else begin
            full_q <= full_d;
            q_q    <= q_d;
        end
    end

    assign full_o = full_q;
    assign q_o    = q_q;

endmodule

// File: rtl/axilite_slave_test.sv
// rtl/axilite_slave_test.sv - AXI-Lite write responder that checks an incrementing address/data sequence
module axilite_slave_test
    import axilite_test_pkg::*;
#(
    parameter int                            AXILITE_ADDR_WIDTH = 64,
    parameter int                            AXILITE_DATA_WIDTH = 64,
    parameter logic [AXILITE_ADDR_WIDTH-1:0] START_ADDR         = AXILITE_ADDR_WIDTH'(DEFAULT_START_ADDR),
    parameter logic [AXILITE_DATA_WIDTH-1:0] START_DATA         = '0,
    parameter logic [3:0]                    STALL_INTERVAL     = 4'd0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXILITE_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXILITE_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [AXILITE_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [AXILITE_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [31:0]                   write_count,
    output logic [15:0]                   err_count,
    output logic                          mismatch
);

    localparam int AW = AXILITE_ADDR_WIDTH;
    localparam int DW = AXILITE_DATA_WIDTH;

    logic [3:0]    stall_cnt_q;
    logic          stall;
    logic          aw_full, w_full, pop, match;
    logic [AW-1:0] aw_q;
    logic [DW-1:0] w_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;
    logic [AW-1:0] exp_addr_q, last_addr_q;
    logic [DW-1:0] exp_data_q, last_data_q;
    logic [31:0]   write_count_q;
    logic [15:0]   err_count_q;
    logic          mismatch_q;
    logic          ar_hs, ar_pend_q, rvalid_q;
    stat_idx_e     ar_sel_q;
    logic [DW-1:0] rdata_q, status_d;
    logic          unused_araddr;

    assign stall = (STALL_INTERVAL != 4'd0) && (stall_cnt_q == STALL_INTERVAL - 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (STALL_INTERVAL != 4'd0) begin
            stall_cnt_q <= stall ? 4'd0 : stall_cnt_q + 4'd1;
        end
    end

    assign pop   = aw_full && w_full && (!bvalid_q || s_axi_bready);
    assign match = (aw_q == exp_addr_q) && (w_q == exp_data_q);

    axilite_chan_hold #(.WIDTH(AW)) u_aw_hold (
        .clk     (clk),
        .rst     (rst),
        .valid_i (s_axi_awvalid),
        .ready_o (s_axi_awready),
        .data_i  (s_axi_awaddr),
        .pop_i   (pop),
        .stall_i (stall),
        .full_o  (aw_full),
        .q_o     (aw_q)
    );

    axilite_chan_hold #(.WIDTH(DW)) u_w_hold (
        .clk     (clk),
        .rst     (rst),
        .valid_i (s_axi_wvalid),
        .ready_o (s_axi_wready),
        .data_i  (s_axi_wdata),
        .pop_i   (pop),
        .stall_i (stall),
        .full_o  (w_full),
        .q_o     (w_q)
    );

    // Expected pointers follow the received beat, so one bad beat is one error.
    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_q      <= 1'b0;
            bresp_q       <= BRESP_OKAY;
            exp_addr_q    <= START_ADDR;
            exp_data_q    <= START_DATA;
            last_addr_q   <= '0;
            last_data_q   <= '0;
            write_count_q <= '0;
            err_count_q   <= '0;
            mismatch_q    <= 1'b0;
        end else begin
            if (pop) begin
                bvalid_q      <= 1'b1;
                bresp_q       <= match ? BRESP_OKAY : BRESP_SLVERR;
                write_count_q <= write_count_q + 32'd1;
                if (!match) begin
                    err_count_q <= sat_inc16(err_count_q);
                    mismatch_q  <= 1'b1;
                end
                exp_addr_q  <= aw_q + AW'(1);
                exp_data_q  <= w_q + DW'(1);
                last_addr_q <= aw_q;
                last_data_q <= w_q;
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        status_d = '0;
        unique case (ar_sel_q)
            STAT_WCOUNT: status_d = DW'(write_count_q);
            STAT_ECOUNT: begin
                status_d         = DW'(err_count_q);
                status_d[DW-1]   = mismatch_q;
            end
            STAT_LADDR:  status_d = DW'(last_addr_q);
            STAT_LDATA:  status_d = last_data_q;
        endcase
    end

    // One pending slot between AR and R, so no second AR is taken until R retires.
    assign s_axi_arready = !rst && !rvalid_q && !ar_pend_q;
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign unused_araddr = ^{s_axi_araddr[AW-1:5], s_axi_araddr[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_pend_q <= 1'b0;
            ar_sel_q  <= STAT_WCOUNT;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ar_pend_q <= ar_hs;
            if (ar_hs) begin
                ar_sel_q <= stat_idx_e'(s_axi_araddr[4:3]);
            end
            if (ar_pend_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= status_d;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = 2'b00;
    assign write_count  = write_count_q;
    assign err_count    = err_count_q;
    assign mismatch     = mismatch_q;

endmodule

// File: tb/tb_axilite_slave_test.sv
// tb/tb_axilite_slave_test.sv - scoreboard bench for axilite_slave_test
module tb_axilite_slave_test;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [63:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [31:0] write_count;
    logic [15:0] err_count;
    logic        mismatch;

    logic [63:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_write_count;
    logic [15:0] s_err_count;
    logic        s_mismatch;

    axilite_slave_test dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .write_count(write_count), .err_count(err_count), .mismatch(mismatch)
    );

    axilite_slave_test #(.STALL_INTERVAL(4'd4)) dut_stall (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_awaddr), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
        .s_axi_wdata(s_wdata), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
        .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
        .s_axi_araddr(s_araddr), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .write_count(s_write_count), .err_count(s_err_count), .mismatch(s_mismatch)
    );

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] wc;
        logic [15:0] ec;
        logic        mm;
    } exp_b_t;

    exp_b_t      sb[$];
    exp_b_t      mon_e;
    logic [63:0] stim_aw[$], stim_w[$];
    int          b_cyc[$], aw_h[$];
    int          cyc = 0;
    int          n_checks = 0, n_pass = 0, s_nb = 0, n_saw, n_sw, h, ha;
    bit          streams_done;
    logic        sa, sw;

    logic [63:0] m_exp_addr, m_exp_data, m_last_addr, m_last_data;
    logic [31:0] m_wc;
    logic [15:0] m_ec;
    logic        m_mm;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic model_reset();
        m_exp_addr = 64'h4000_0000; m_exp_data = 64'h0;
        m_last_addr = 64'h0; m_last_data = 64'h0;
        m_wc = 0; m_ec = 0; m_mm = 1'b0;
        sb.delete(); stim_aw.delete(); stim_w.delete();
    endtask

    // A pair is good iff it continues from the previous received pair (or the start values).
    task automatic push_pair(input logic [63:0] a, input logic [63:0] d);
        bit ok;
        stim_aw.push_back(a);
        stim_w.push_back(d);
        ok = (a == m_exp_addr) && (d == m_exp_data);
        m_wc = m_wc + 1;
        if (!ok) begin
            if (m_ec != 16'hFFFF) m_ec = m_ec + 1;
            m_mm = 1'b1;
        end
        sb.push_back('{ok ? 2'b00 : 2'b10, m_wc, m_ec, m_mm});
        m_exp_addr = a + 1; m_exp_data = d + 1;
        m_last_addr = a; m_last_data = d;
    endtask

    always @(negedge clk) begin
        if (!rst && bvalid && bready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL b_unexpected: bvalid 1 with no pair outstanding, required 0");
            end else begin
                mon_e = sb.pop_front();
                chk("bresp", bresp, mon_e.resp);
                chk("b_write_count", write_count, mon_e.wc);
                chk("b_err_count", err_count, mon_e.ec);
                chk("b_mismatch", mismatch, mon_e.mm);
                b_cyc.push_back(cyc);
            end
        end
        if (!rst && s_bvalid && s_bready) begin
            s_nb++;
            chk("stall_bresp", s_bresp, 2'b00);
        end
    end

    task automatic send_aw(input logic [63:0] a, output int hs);
        int t;
        t = 0; awaddr = a; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && t < 200) begin @(negedge clk); t++; end
        if (!awready) begin n_checks++; $display("FAIL aw_timeout: awready 0, required 1"); end
        @(posedge clk); #1;
        hs = cyc; awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, output int hs);
        int t;
        t = 0; wdata = d; wvalid = 1'b1;
        @(negedge clk);
        while (!wready && t < 200) begin @(negedge clk); t++; end
        if (!wready) begin n_checks++; $display("FAIL w_timeout: wready 0, required 1"); end
        @(posedge clk); #1;
        hs = cyc; wvalid = 1'b0;
    endtask

    task automatic aw_stream(input int gap);
        int hh;
        while (stim_aw.size() > 0) begin
            repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
            send_aw(stim_aw.pop_front(), hh);
            aw_h.push_back(hh);
        end
    endtask

    task automatic w_stream(input int gap);
        int hh;
        while (stim_w.size() > 0) begin
            repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
            send_w(stim_w.pop_front(), hh);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 2000) begin @(posedge clk); #1; t++; end
        if (sb.size() > 0) begin n_checks++; $display("FAIL drain_timeout: %0d B beats missing, required 0", sb.size()); end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_read(input logic [1:0] idx, input logic [63:0] req, input string name);
        int t;
        t = 0;
        araddr = (64'(idx) << 3) | 64'($urandom_range(0, 7)) | (64'($urandom_range(0, 15)) << 5);
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && t < 50) begin @(negedge clk); t++; end
        if (!arready) begin n_checks++; $display("FAIL ar_timeout: arready 0, required 1"); end
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk({name, "_rvalid_gap"}, rvalid, 1'b0);
        @(negedge clk);
        chk({name, "_rvalid"}, rvalid, 1'b1);
        chk({name, "_rresp"}, rresp, 2'b00);
        chk(name, rdata, req);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        awvalid = 0; wvalid = 0; bready = 1; arvalid = 0; rready = 1;
        awaddr = 0; wdata = 0; araddr = 0;
        s_awvalid = 0; s_wvalid = 0; s_bready = 1; s_arvalid = 0; s_rready = 1;
        s_awaddr = 0; s_wdata = 0; s_araddr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_counts", {write_count, err_count, mismatch}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Stall instance: counter restarts at 0 in this first cycle after reset
        s_awvalid = 1; s_wvalid = 1; s_awaddr = 64'h4000_0000; s_wdata = 0;
        n_saw = 0; n_sw = 0;
        for (int k = 0; k < 200 && (n_saw < 12 || n_sw < 12); k++) begin
            @(negedge clk);
            sa = s_awready; sw = s_wready;
            if (k == 0) begin
                chk("post_rst_awready", awready, 1);
                chk("post_rst_wready", wready, 1);
                chk("post_rst_arready", arready, 1);
            end
            if (k < 16) begin
                chk("stall_awready", sa, (k % 4) != 3);
                chk("stall_wready", sw, (k % 4) != 3);
            end
            @(posedge clk); #1;
            if (sa && s_awvalid) begin
                n_saw++; s_awaddr = 64'h4000_0000 + 64'(n_saw);
                if (n_saw == 12) s_awvalid = 0;
            end
            if (sw && s_wvalid) begin
                n_sw++; s_wdata = 64'(n_sw);
                if (n_sw == 12) s_wvalid = 0;
            end
        end
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("stall_b_beats", s_nb, 12);
        chk("stall_write_count", s_write_count, 12);
        chk("stall_err_count", s_err_count, 0);
        @(posedge clk); #1;

        // Back-to-back, AW and W together
        b_cyc.delete(); aw_h.delete();
        for (int i = 0; i < 10; i++) push_pair(64'h4000_0000 + 64'(i), 64'(i));
        fork aw_stream(0); w_stream(0); join
        wait_drain();
        chk("b2b_beats", b_cyc.size(), 10);
        chk("b2b_first_latency", b_cyc[0] - aw_h[0], 1);
        for (int i = 1; i < b_cyc.size(); i++) chk("b2b_spacing", b_cyc[i] - b_cyc[i-1], 1);
        @(negedge clk);
        chk("b2b_write_count", write_count, 10);
        chk("b2b_err_count", err_count, 0);
        @(posedge clk); #1;

        // W leads AW by 3 cycles
        push_pair(64'h4000_000A, 64'd10);
        send_w(stim_w.pop_front(), h);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wlead_wready", wready, 0);
            chk("wlead_awready", awready, 1);
            @(posedge clk); #1;
        end
        b_cyc.delete();
        send_aw(stim_aw.pop_front(), ha);
        wait_drain();
        chk("wlead_b_latency", b_cyc[0] - ha, 1);

        // Single corrupted data beat, then resync
        do_reset();
        push_pair(64'h4000_0000, 64'h0);
        push_pair(64'h4000_0001, 64'h1);
        push_pair(64'h4000_0002, 64'h55);
        push_pair(64'h4000_0003, 64'h56);
        fork aw_stream(1); w_stream(1); join
        wait_drain();
        @(negedge clk);
        chk("resync_mismatch", mismatch, 1);
        chk("resync_err_count", err_count, 1);
        chk("resync_write_count", write_count, 4);
        @(posedge clk); #1;

        // B backpressure with two pairs offered
        bready = 0;
        push_pair(64'h4000_0004, 64'h57);
        push_pair(64'h4000_0005, 64'h58);
        fork aw_stream(0); w_stream(0); join
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_bvalid", bvalid, 1);
            chk("hold_bresp", bresp, sb[0].resp);
            chk("hold_write_count", write_count, sb[0].wc);
            chk("hold_readies", {awready, wready}, 2'b00);
            @(posedge clk); #1;
        end
        b_cyc.delete();
        bready = 1;
        wait_drain();
        chk("hold_release_beats", b_cyc.size(), 2);
        chk("hold_release_spacing", b_cyc[1] - b_cyc[0], 1);

        // Randomised sequence with occasional corruption, random gaps and bready
        begin
            logic [63:0] ga, gd, a, d;
            ga = m_exp_addr; gd = m_exp_data;
            for (int i = 0; i < 40; i++) begin
                a = ga; d = gd;
                case ($urandom_range(0, 7))
                    0: a = a ^ (64'h1 << $urandom_range(0, 63));
                    1: d = {$urandom, $urandom};
                    default: ;
                endcase
                push_pair(a, d);
                ga = a + 1; gd = d + 1;
            end
        end
        streams_done = 0;
        fork
            begin
                fork aw_stream(3); w_stream(3); join
                streams_done = 1;
            end
            begin
                int t;
                t = 0;
                while ((!streams_done || sb.size() > 0) && t < 2000) begin
                    bready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                    t++;
                end
                bready = 1;
            end
        join
        wait_drain();
        do_read(2'd0, 64'(m_wc), "rd_wcount");
        do_read(2'd1, {m_mm, 47'h0, m_ec}, "rd_ecount");
        do_read(2'd2, m_last_addr, "rd_laddr");
        do_read(2'd3, m_last_data, "rd_ldata");

        // Reset with a held W beat and a pending AR
        send_w(64'h1234, h);
        araddr = 64'h8; arvalid = 1;
        @(posedge clk); #1;
        arvalid = 0;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_readies", {awready, wready, arready}, 3'b000);
        chk("midrst_valids", {bvalid, rvalid}, 2'b00);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_counts", {write_count, err_count, mismatch}, 0);
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_wready", wready, 1);
            chk("postrst_rvalid", rvalid, 0);
            @(posedge clk); #1;
        end
        push_pair(64'h4000_0000, 64'h0);
        fork aw_stream(0); w_stream(0); join
        wait_drain();
        @(negedge clk);
        chk("postrst_write_count", write_count, 1);
        chk("postrst_err_count", err_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
